// File: rtl/rr_merge4_if.sv
// Handshake bundle for the four-to-one round-robin merger: four source
// channels (data/valid/ready) and one tagged, registered output stream.
interface rr_merge4_if #(
  parameter int W = 8
);
  logic [W-1:0] din0;
  logic [W-1:0] din1;
  logic [W-1:0] din2;
  logic [W-1:0] din3;
  logic         vin0;
  logic         vin1;
  logic         vin2;
  logic         vin3;
  logic         rdy0;
  logic         rdy1;
  logic         rdy2;
  logic         rdy3;
  logic [W-1:0] dout;
  logic [1:0]   sel;
  logic         vout;
  logic         rin;

  // Environment side: drives sources and downstream ready.
  modport master (
    output din0, din1, din2, din3,
    output vin0, vin1, vin2, vin3,
    output rin,
    input  rdy0, rdy1, rdy2, rdy3,
    input  dout, sel, vout
  );

  // Merger side.
  modport slave (
    input  din0, din1, din2, din3,
    input  vin0, vin1, vin2, vin3,
    input  rin,
    output rdy0, rdy1, rdy2, rdy3,
    output dout, sel, vout
  );
endinterface

// File: rtl/rr_merge4.sv
// Four-to-one round-robin merger. Grants at most one source per cycle,
// scanning from the pointer channel, and registers the granted word together
// with its 2-bit channel index. The pointer moves just past the last winner.
module rr_merge4 #(
  parameter int W = 8
) (
  input  logic     clk,
  input  logic     rst,
  rr_merge4_if.slave bus
);

  logic [W-1:0] din [4];
  logic [3:0]   vin;
  logic [3:0]   rdy;
  logic [W-1:0] dout_q;
  logic [1:0]   sel_q;
  logic         vout_q;
  logic [1:0]   ptr;
  logic         load;
  logic         found;
  logic [1:0]   gidx;
  logic [1:0]   idx;
  logic         xfer;

  assign din[0] = bus.din0;
  assign din[1] = bus.din1;
  assign din[2] = bus.din2;
  assign din[3] = bus.din3;
  assign vin    = {bus.vin3, bus.vin2, bus.vin1, bus.vin0};

  assign load = !vout_q || bus.rin;

  // Pick the first valid channel starting at ptr; grant only when the output
  // register can take a word and reset is not asserted.
  always_comb begin
    found = 1'b0;
    gidx  = ptr;
    idx   = ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && vin[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    rdy = '0;
    if (load && found && !rst) begin
      rdy[gidx] = 1'b1;
    end
  end

  assign xfer = |rdy;

  assign bus.rdy0 = rdy[0];
  assign bus.rdy1 = rdy[1];
  assign bus.rdy2 = rdy[2];
  assign bus.rdy3 = rdy[3];

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      sel_q  <= '0;
      vout_q <= 1'b0;
      ptr    <= '0;
    end else if (xfer) begin
      dout_q <= din[gidx];
      sel_q  <= gidx;
      vout_q <= 1'b1;
      ptr    <= gidx + 2'd1;
    end else if (load) begin
      vout_q <= 1'b0;
    end
  end

  assign bus.dout = dout_q;
  assign bus.sel  = sel_q;
  assign bus.vout = vout_q;

endmodule

// File: tb/tb_rr_merge4.sv
// Self-checking bench for rr_merge4: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the merger.
module tb_rr_merge4;

  logic clk;
  logic rst;

  rr_merge4_if #(.W(8)) bus ();

  rr_merge4 #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state.
  int         m_ptr;
  int         m_sel;
  logic [7:0] m_dout;
  logic       m_vout;

  function automatic logic [3:0] model_grant(input logic [3:0] v, input logic r);
    logic [3:0] g;
    g = '0;
    if (m_vout && !r) return g;
    for (int k = 0; k < 4; k++) begin
      if (v[(m_ptr + k) % 4]) begin
        g[(m_ptr + k) % 4] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_sel  = 0;
    m_dout = 8'h00;
    m_vout = 1'b0;
  endtask

  task automatic apply(input logic [3:0] v, input logic [31:0] d, input logic r);
    bus.vin0 = v[0];
    bus.vin1 = v[1];
    bus.vin2 = v[2];
    bus.vin3 = v[3];
    bus.din0 = d[7:0];
    bus.din1 = d[15:8];
    bus.din2 = d[23:16];
    bus.din3 = d[31:24];
    bus.rin  = r;
  endtask

  // One clock of stimulus: drive after the falling edge, sample grants before
  // the rising edge, advance the model, return just after the rising edge.
  task automatic drive_cycle(input logic [3:0] v, input logic [31:0] d, input logic r,
                             output logic [3:0] obs, output logic [3:0] exp);
    @(negedge clk);
    apply(v, d, r);
    #1;
    obs = {bus.rdy3, bus.rdy2, bus.rdy1, bus.rdy0};
    exp = model_grant(v, r);
    @(posedge clk);
    if (exp != 4'b0000) begin
      for (int k = 0; k < 4; k++) begin
        if (exp[k]) begin
          m_dout = d[k*8 +: 8];
          m_sel  = k;
          m_vout = 1'b1;
          m_ptr  = (k + 1) % 4;
        end
      end
    end else if (!m_vout || r) begin
      m_vout = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    apply(4'b0000, 32'h0, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] obs, exp;
    vectors++;
    if ({bus.dout, bus.sel, bus.vout} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_state: got dout=%h sel=%0d vout=%b, want 00/0/0", bus.dout, bus.sel, bus.vout);
    end
    do_reset();
    drive_cycle(4'b1111, 32'h44332211, 1'b0, obs, exp);
    vectors++;
    if (bus.vout !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_preload: vout=%b want 1", bus.vout);
    end
    // Assert reset between clock edges: outputs must clear immediately.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.dout, bus.sel, bus.vout} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_async: got dout=%h sel=%0d vout=%b, want 00/0/0", bus.dout, bus.sel, bus.vout);
    end
    vectors++;
    if ({bus.rdy3, bus.rdy2, bus.rdy1, bus.rdy0} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_rdy: got %b want 0000", {bus.rdy3, bus.rdy2, bus.rdy1, bus.rdy0});
    end
    model_reset();
    apply(4'b0000, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive_cycle(4'b0100, 32'h00C30000, 1'b1, obs, exp);
    vectors++;
    if (obs !== 4'b0100 || obs !== exp) begin
      miscompares++;
      $display("FAIL reset_first_grant: got %b want 0100 (model %b)", obs, exp);
    end
    vectors++;
    if (bus.sel !== 2'd2 || bus.dout !== 8'hC3 || bus.vout !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_word: got sel=%0d dout=%h vout=%b want 2/c3/1", bus.sel, bus.dout, bus.vout);
    end
  endtask

  task automatic test_single_channel();
    logic [3:0] obs, exp;
    do_reset();
    drive_cycle(4'b0010, 32'h0000A500, 1'b1, obs, exp);
    vectors++;
    if (obs !== 4'b0010) begin
      miscompares++;
      $display("FAIL single_rdy: got %b want 0010", obs);
    end
    vectors++;
    if (bus.dout !== 8'hA5 || bus.sel !== 2'd1 || bus.vout !== 1'b1) begin
      miscompares++;
      $display("FAIL single_word: got dout=%h sel=%0d vout=%b want a5/1/1", bus.dout, bus.sel, bus.vout);
    end
    drive_cycle(4'b0000, 32'h0, 1'b1, obs, exp);
    vectors++;
    if (bus.vout !== 1'b0 || bus.dout !== 8'hA5 || bus.sel !== 2'd1) begin
      miscompares++;
      $display("FAIL single_drain: got dout=%h sel=%0d vout=%b want a5/1/0", bus.dout, bus.sel, bus.vout);
    end
  endtask

  task automatic test_contention();
    logic [3:0] obs, exp;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive_cycle(4'b1111, 32'h13121110, 1'b1, obs, exp);
      vectors++;
      if (obs !== (4'b0001 << (k % 4))) begin
        miscompares++;
        $display("FAIL contention_rdy[%0d]: got %b want %b", k, obs, 4'b0001 << (k % 4));
      end
      vectors++;
      if (bus.sel !== 2'(k % 4) || bus.dout !== 8'(8'h10 + k % 4) || bus.vout !== 1'b1) begin
        miscompares++;
        $display("FAIL contention_word[%0d]: got sel=%0d dout=%h vout=%b want %0d/%h/1",
                 k, bus.sel, bus.dout, bus.vout, k % 4, 8'h10 + k % 4);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] obs, exp;
    do_reset();
    drive_cycle(4'b1000, 32'h7E000000, 1'b1, obs, exp);
    vectors++;
    if (bus.sel !== 2'd3 || bus.vout !== 1'b1 || bus.dout !== 8'h7E) begin
      miscompares++;
      $display("FAIL bp_setup: got sel=%0d dout=%h vout=%b want 3/7e/1", bus.sel, bus.dout, bus.vout);
    end
    for (int k = 0; k < 3; k++) begin
      drive_cycle(4'b0101, 32'h00220011, 1'b0, obs, exp);
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp_stall_rdy[%0d]: got %b want 0000", k, obs);
      end
      vectors++;
      if (bus.sel !== 2'd3 || bus.vout !== 1'b1 || bus.dout !== 8'h7E) begin
        miscompares++;
        $display("FAIL bp_stall_hold[%0d]: got sel=%0d dout=%h vout=%b want 3/7e/1",
                 k, bus.sel, bus.dout, bus.vout);
      end
    end
    drive_cycle(4'b0101, 32'h00220011, 1'b1, obs, exp);
    vectors++;
    if (obs !== 4'b0001) begin
      miscompares++;
      $display("FAIL bp_release_rdy: got %b want 0001", obs);
    end
    vectors++;
    if (bus.sel !== 2'd0 || bus.dout !== 8'h11 || bus.vout !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_word: got sel=%0d dout=%h vout=%b want 0/11/1", bus.sel, bus.dout, bus.vout);
    end
  endtask

  task automatic test_priority_skip();
    logic [3:0] obs, exp;
    do_reset();
    drive_cycle(4'b0001, 32'h00000055, 1'b1, obs, exp);
    drive_cycle(4'b1001, 32'h99000066, 1'b1, obs, exp);
    vectors++;
    if (obs !== 4'b1000) begin
      miscompares++;
      $display("FAIL skip_rdy: got %b want 1000", obs);
    end
    vectors++;
    if (bus.sel !== 2'd3 || bus.dout !== 8'h99) begin
      miscompares++;
      $display("FAIL skip_word: got sel=%0d dout=%h want 3/99", bus.sel, bus.dout);
    end
    drive_cycle(4'b0001, 32'h00000066, 1'b1, obs, exp);
    vectors++;
    if (obs !== 4'b0001) begin
      miscompares++;
      $display("FAIL skip_wrap_rdy: got %b want 0001", obs);
    end
  endtask

  task automatic test_random();
    logic [3:0]  obs, exp;
    logic [3:0]  v;
    logic [31:0] d;
    logic        r;
    do_reset();
    v = '0;
    d = '0;
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (!v[k] && ($urandom % 3 != 0)) begin
          v[k] = 1'b1;
          d[k*8 +: 8] = 8'($urandom);
        end
      end
      r = ($urandom % 4 != 0);
      drive_cycle(v, d, r, obs, exp);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL random_rdy[%0d]: got %b want %b", n, obs, exp);
      end
      vectors++;
      if (bus.vout !== m_vout || (m_vout && (bus.dout !== m_dout || bus.sel !== 2'(m_sel)))) begin
        miscompares++;
        $display("FAIL random_out[%0d]: got dout=%h sel=%0d vout=%b want %h/%0d/%b",
                 n, bus.dout, bus.sel, bus.vout, m_dout, m_sel, m_vout);
      end
      v = v & ~obs;
    end
  endtask

  // A 1-to-4 distributor fed by sel/dout[0] should put each bit back on the
  // index of the channel it came from.
  task automatic test_loopback();
    logic [3:0]  obs, exp;
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  pat;
    logic [3:0]  lb;
    for (int round = 0; round < 3; round++) begin
      pat = 4'($urandom);
      lb  = ~pat;
      v   = 4'b1111;
      for (int k = 0; k < 4; k++) begin
        d[k*8 +: 8] = {7'($urandom), pat[k]};
      end
      for (int n = 0; n < 6; n++) begin
        drive_cycle(v, d, 1'b1, obs, exp);
        if (bus.vout === 1'b1) lb[bus.sel] = bus.dout[0];
        v = v & ~obs;
      end
      vectors++;
      if (lb !== pat) begin
        miscompares++;
        $display("FAIL loopback[%0d]: got %b want %b", round, lb, pat);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    apply(4'b0000, 32'h0, 1'b0);
    model_reset();
    #1;
    test_reset();
    test_single_channel();
    test_contention();
    test_backpressure();
    test_priority_skip();
    test_random();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_merge4.md
# rr_merge4

Four-to-one round-robin merger with valid/ready handshakes on every port. It collects words from four independent source channels onto one registered output stream. Each output word is tagged with the 2-bit index of its source channel. The block is the collecting end of the lab's 1-to-4 channel distributor: its `sel`/`dout` pair can drive the distributor's `sel`/`din` directly, so a word returns to the channel index it came from.

## Interface

- `W`, 8, data width of every channel and of the output.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `din0`..`din3`  in  W each  channel data.
- `vin0`..`vin3`  in  1 each  channel valid.
- `rdy0`..`rdy3`  out  1 each  channel ready (grant). Combinational.
- `dout`  out  W  output data, registered.
- `sel`  out  2  source channel index of `dout`, registered.
- `vout`  out  1  output valid, registered.
- `rin`  in  1  downstream ready.

## Operation

- **State**
  - Output register holds `dout`, `sel` and `vout`.
  - Round-robin pointer `ptr` is 2 bits and names the highest-priority channel.
- **Reset values:** `dout`=0, `sel`=0, `vout`=0, `ptr`=0. All `rdyK` are 0 while `rst` is high.
- **Load condition:** `load` = `!vout || rin`. The output register can accept a new word this cycle.
- **Arbitration** (combinational)
  - Only when `load` is 1: scan channels in the order `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
  - Grant the first channel K with `vinK`=1, and drive `rdyK`=1.
  - All other `rdy` outputs are 0. At most one `rdy` is high in any cycle.
- **Transfer on channel K:** `vinK && rdyK`. At the next edge:
  - `dout` ← `dinK`, `sel` ← K, `vout` ← 1.
  - `ptr` ← (K+1) mod 4.
- **Load with no request** (`load`=1, no `vin` asserted): `vout` ← 0 at the next edge. `dout`, `sel` and `ptr` hold.
- **Stall** (`load`=0, i.e. `vout`=1 and `rin`=0)
  - All `rdy` are 0.
  - `dout`, `sel`, `vout` and `ptr` hold.
- **Downstream transfer:** occurs when `vout && rin`. On the same edge the register either reloads from a granted channel or clears `vout`.
- **Source rules:**
  - A source holds `dinK` and `vinK` stable until it sees `rdyK`=1.
  - `vinK` does not depend combinationally on `rdyK`.
- **Width rules:**
  - Data passes through unmodified; no arithmetic on data.
  - `ptr` and `sel` wrap naturally from 3 to 0.

## Timing

- **Latency:** one cycle from an input transfer to the word appearing on `dout`/`vout`.
- **Throughput**
  - One word per cycle while `rin`=1 and at least one `vin` is high.
  - No bubble cycle between consecutive words.
- **Combinational path:** `rdyK` depends on `vin0..3`, `rin`, `vout` and `ptr`. `rin` → `rdyK` is the only combinational path from downstream to upstream.
- **Fairness:**
  - With all four channels continuously valid, grants rotate 0,1,2,3,0,…
  - A continuously valid channel waits at most 3 output transfers.
- **Reset mid-operation**
  - The word in the output register is discarded and `vout` drops immediately (asynchronously).
  - Arbitration restarts with channel 0 at highest priority after `rst` falls.
  - An input transfer in the cycle `rst` asserts is lost. Sources are reset together with this block.

## Test plan

- **Reset:** assert `rst` mid-stream with `vout`=1 → `vout`, `dout` and `sel` go to 0 without waiting for `clk`; all `rdy` are 0. After release, a request on channel 2 only is granted first.
- **Single channel:** `vin1`=1, `din1`=8'hA5, `rin`=1 → `rdy1`=1 in that cycle; next cycle `dout`=8'hA5, `sel`=1, `vout`=1. Then drop `vin1` → `vout`=0 one cycle later.
- **Full contention:** all `vin`=1 with `dinK`=8'h10+K, `rin`=1 for 8 cycles → `sel` sequence 0,1,2,3,0,1,2,3 and `dout` 10,11,12,13,10,… back-to-back with no gap.
- **Backpressure:** `vout`=1 with `sel`=3 held, `rin`=0 for 3 cycles while `vin0` and `vin2` are high → all `rdy` stay 0 and outputs are unchanged. When `rin` rises, `rdy0` is granted (pointer wrapped 3→0); next cycle `sel`=0.
- **Priority skip:** `ptr`=1, only `vin0` and `vin3` high → `rdy3` granted; next cycle `sel`=3 and `ptr`=0, then `rdy0` is granted.
- **Loopback:** connect `sel`/`dout` (bit 0) into the 1-to-4 distributor → each bit reappears on the output matching its source channel index.
